// File: rtl/uart_frame_packer.sv
// uart_frame_packer
// Feeds a UART 8N1 transmitter from a stream of WORD_WIDTH-bit words.
// Words are buffered in a small FIFO and sent least-significant byte first.
// Every frame of FRAME_LEN words is preceded by one SYNC_BYTE.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   in_data_i    input word
//   in_valid_i   input word valid
//   in_ready_o   FIFO can accept a word (registered)
//   tx_data_o    byte to the UART tx block
//   tx_enable_o  start request to the UART tx block
//   tx_busy_i    UART tx busy; registered once before use
//   fifo_count_o words currently stored (registered)
//   frame_done_o one-cycle pulse after the last byte of a frame completes
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for a stored word; choose header or next word
// HDR_REQ   | present SYNC_BYTE with tx_enable until busy seen
// HDR_WAIT  | wait for the header byte to finish
// LOAD      | pop one word into the shift register
// BYTE_REQ  | present current byte with tx_enable until busy seen
// BYTE_WAIT | wait for the byte to finish; next byte, or end of word

module uart_frame_packer #(
    parameter int         WORD_WIDTH = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter int         FRAME_LEN  = 64,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [WORD_WIDTH-1:0]         in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [7:0]                    tx_data_o,
    output logic                          tx_enable_o,
    input  logic                          tx_busy_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          frame_done_o
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int WCW   = $clog2(FRAME_LEN + 1);
    localparam int BIW   = $clog2(BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_REQ,
        HDR_WAIT,
        LOAD,
        BYTE_REQ,
        BYTE_WAIT
    } state_t;

    state_t                state_q;

    // ---------------- FIFO ----------------
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  in_ready_q;
    logic                  wr_en;
    logic                  pop_en;

    assign wr_en  = in_valid_i & in_ready_q;
    // LOAD is only reached with at least one word stored, so the pop never underflows.
    assign pop_en = (state_q == LOAD);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            // Derived from the next count so it always agrees with fifo_count_o.
            in_ready_q <= (count_d < CW'(FIFO_DEPTH));
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    // ---------------- byte serialiser FSM ----------------
    logic [WORD_WIDTH-1:0] sreg_q;
    logic [WORD_WIDTH-1:0] sreg_shift;
    logic [BIW-1:0]        byte_idx_q;
    logic [WCW-1:0]        word_cnt_q;
    logic                  busy_q;
    logic [7:0]            tx_data_q;
    logic                  tx_enable_q;
    logic                  frame_done_q;

    // The current byte always sits in the low bits; the next one is exposed by a shift.
    assign sreg_shift = sreg_q >> 8;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            byte_idx_q   <= '0;
            word_cnt_q   <= '0;
            busy_q       <= 1'b0;
            tx_data_q    <= '0;
            tx_enable_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            busy_q       <= tx_busy_i;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        if (word_cnt_q == '0) begin
                            tx_data_q   <= SYNC_BYTE;
                            tx_enable_q <= 1'b1;
                            state_q     <= HDR_REQ;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                HDR_REQ: begin
                    if (busy_q) begin
                        tx_enable_q <= 1'b0;
                        state_q     <= HDR_WAIT;
                    end
                end
                HDR_WAIT: begin
                    if (!busy_q) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    sreg_q      <= mem_q[rd_ptr_q];
                    tx_data_q   <= mem_q[rd_ptr_q][7:0];
                    byte_idx_q  <= '0;
                    tx_enable_q <= 1'b1;
                    state_q     <= BYTE_REQ;
                end
                BYTE_REQ: begin
                    if (busy_q) begin
                        tx_enable_q <= 1'b0;
                        state_q     <= BYTE_WAIT;
                    end
                end
                BYTE_WAIT: begin
                    if (!busy_q) begin
                        if (byte_idx_q < BIW'(BYTES - 1)) begin
                            byte_idx_q  <= byte_idx_q + BIW'(1);
                            sreg_q      <= sreg_shift;
                            tx_data_q   <= sreg_shift[7:0];
                            tx_enable_q <= 1'b1;
                            state_q     <= BYTE_REQ;
                        end else begin
                            if (word_cnt_q == WCW'(FRAME_LEN - 1)) begin
                                word_cnt_q   <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                word_cnt_q <= word_cnt_q + WCW'(1);
                            end
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_enable_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign fifo_count_o = count_q;
    assign tx_data_o    = tx_data_q;
    assign tx_enable_o  = tx_enable_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: a behavioural UART tx model checks every
// started byte against a scoreboard of bytes predicted from the words sent.
module tb_uart_frame_packer;

    localparam int WW = 16;
    localparam int FD = 8;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    tx_data;
    logic          tx_enable;
    logic          tx_busy = 1'b0;
    logic [3:0]    fifo_count;
    logic          frame_done;

    always #5 clk = ~clk;

    uart_frame_packer #(
        .WORD_WIDTH(WW),
        .FIFO_DEPTH(FD),
        .FRAME_LEN (FL),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .tx_data_o   (tx_data),
        .tx_enable_o (tx_enable),
        .tx_busy_i   (tx_busy),
        .fifo_count_o(fifo_count),
        .frame_done_o(frame_done)
    );

    int         vec = 0;
    int         mis = 0;
    logic [7:0] sb[$];
    int         tb_wc = 0;
    int         busy_len = 10;
    int         busy_delay = 0;
    int         mstate = 0;
    int         age = 0;
    int         wcnt = 0;
    int         starts = 0;
    int         fd_cnt = 0;
    int         fd_starts = 0;
    logic       fd_prev = 1'b0;
    logic [7:0] cap = '0;
    logic [7:0] exp_b;
    bit         chk_rdy = 1'b0;
    int         max_cnt = 0;

    // UART tx model: accepts a start, optionally delays busy, holds busy for busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_busy = 1'b0;
                mstate  = 0;
            end else begin
                case (mstate)
                    0: begin
                        if (tx_enable) begin
                            starts++;
                            cap = tx_data;
                            vec++;
                            if (sb.size() == 0) begin
                                mis++;
                                $display("FAIL byte_unexpected got=%02h expected=none", tx_data);
                            end else begin
                                exp_b = sb.pop_front();
                                if (tx_data !== exp_b) begin
                                    mis++;
                                    $display("FAIL byte_order got=%02h expected=%02h", tx_data, exp_b);
                                end
                            end
                            if (busy_delay == 0) begin
                                tx_busy = 1'b1;
                                age     = 0;
                                mstate  = 2;
                            end else begin
                                wcnt   = busy_delay;
                                mstate = 1;
                            end
                        end
                    end
                    1: begin
                        vec++;
                        if (tx_enable !== 1'b1 || tx_data !== cap) begin
                            mis++;
                            $display("FAIL hold_before_busy en=%b data=%02h expected en=1 data=%02h",
                                     tx_enable, tx_data, cap);
                        end
                        wcnt--;
                        if (wcnt == 0) begin
                            tx_busy = 1'b1;
                            age     = 0;
                            mstate  = 2;
                        end
                    end
                    default: begin
                        age++;
                        vec++;
                        if (tx_data !== cap) begin
                            mis++;
                            $display("FAIL data_stable_busy got=%02h expected=%02h", tx_data, cap);
                        end
                        vec++;
                        if (tx_enable !== ((age < 2) ? 1'b1 : 1'b0)) begin
                            mis++;
                            $display("FAIL enable_drop age=%0d got=%b expected=%b",
                                     age, tx_enable, (age < 2));
                        end
                        if (age >= busy_len) begin
                            tx_busy = 1'b0;
                            mstate  = 0;
                        end
                    end
                endcase
            end
        end
    end

    // frame_done pulse and ready/count monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            fd_prev = 1'b0;
        end else begin
            if (frame_done) begin
                fd_cnt++;
                fd_starts = starts;
                vec++;
                if (fd_prev) begin
                    mis++;
                    $display("FAIL frame_done_width got=2+ cycles expected=1");
                end
            end
            fd_prev = frame_done;
            if (chk_rdy) begin
                if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
                vec++;
                if (in_ready !== (fifo_count < 4'd8) || fifo_count > 4'd8) begin
                    mis++;
                    $display("FAIL ready_vs_count in_ready=%b count=%0d", in_ready, fifo_count);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        tb_wc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int t;
        if (tb_wc == 0) sb.push_back(8'hA5);
        sb.push_back(w[7:0]);
        sb.push_back(w[15:8]);
        tb_wc    = (tb_wc + 1) % FL;
        in_data  = w;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) begin
            vec++;
            mis++;
            $display("FAIL accept_timeout word=%04h in_ready=%b expected=1", w, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || mstate != 0 || fifo_count != 0) && t < 30000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        vec++;
        if (sb.size() != 0 || t >= 30000) begin
            mis++;
            $display("FAIL drain pending_bytes=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vec += 5;
        if (tx_data !== 8'h00)   begin mis++; $display("FAIL rst_tx_data got=%02h expected=00", tx_data); end
        if (tx_enable !== 1'b0)  begin mis++; $display("FAIL rst_tx_enable got=%b expected=0", tx_enable); end
        if (frame_done !== 1'b0) begin mis++; $display("FAIL rst_frame_done got=%b expected=0", frame_done); end
        if (fifo_count !== 4'd0) begin mis++; $display("FAIL rst_fifo_count got=%0d expected=0", fifo_count); end
        if (in_ready !== 1'b0)   begin mis++; $display("FAIL rst_in_ready got=%b expected=0", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec++;
        if (in_ready !== 1'b1) begin mis++; $display("FAIL post_rst_ready got=%b expected=1", in_ready); end
    endtask

    task automatic test_single_word();
        do_reset();
        busy_len = 10;
        send_word(16'h1234);
        drain();
        vec++;
        if (in_ready !== 1'b1) begin mis++; $display("FAIL single_ready got=%b expected=1", in_ready); end
    endtask

    task automatic test_full_frame();
        int fd0;
        int s0;
        do_reset();
        busy_len = 10;
        fd0 = fd_cnt;
        s0  = starts;
        for (int i = 1; i <= 4; i++) send_word(WW'(i));
        drain();
        vec++;
        if (fd_cnt - fd0 != 1) begin mis++; $display("FAIL frame_done_count got=%0d expected=1", fd_cnt - fd0); end
        vec++;
        if (fd_starts - s0 != 9) begin mis++; $display("FAIL frame_done_pos got=%0d expected=9", fd_starts - s0); end
        send_word(16'h0005);
        drain();
        vec++;
        if (fd_cnt - fd0 != 1) begin mis++; $display("FAIL frame_done_extra got=%0d expected=1", fd_cnt - fd0); end
    endtask

    task automatic test_back_to_back_full();
        do_reset();
        busy_len = 100;
        max_cnt  = 0;
        chk_rdy  = 1'b1;
        for (int i = 0; i < 20; i++) send_word(16'h1000 + WW'(i) * 16'h0101);
        drain();
        chk_rdy = 1'b0;
        vec++;
        if (max_cnt != 8) begin mis++; $display("FAIL fifo_full_reached got=%0d expected=8", max_cnt); end
        busy_len = 10;
    endtask

    task automatic test_reset_mid();
        int s0;
        int t;
        do_reset();
        busy_len = 10;
        s0 = starts;
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        t = 0;
        while (!(starts - s0 >= 4 && mstate == 2 && age >= 3) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        vec++;
        if (t >= 2000) begin mis++; $display("FAIL mid_wait_timeout starts=%0d expected>=4", starts - s0); end
        rst_n = 1'b0;
        sb.delete();
        tb_wc = 0;
        #1;
        vec += 3;
        if (tx_enable !== 1'b0)  begin mis++; $display("FAIL mid_rst_enable got=%b expected=0", tx_enable); end
        if (tx_data !== 8'h00)   begin mis++; $display("FAIL mid_rst_data got=%02h expected=00", tx_data); end
        if (fifo_count !== 4'd0) begin mis++; $display("FAIL mid_rst_count got=%0d expected=0", fifo_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(16'hBEEF);
        drain();
    endtask

    task automatic test_late_busy();
        int s0;
        do_reset();
        busy_len   = 10;
        busy_delay = 20;
        s0 = starts;
        send_word(16'h5A3C);
        drain();
        vec++;
        if (starts - s0 != 3) begin mis++; $display("FAIL late_busy_starts got=%0d expected=3", starts - s0); end
        busy_delay = 0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_frame();
        test_back_to_back_full();
        test_reset_mid();
        test_late_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout time=%0t expected=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
